sequence_recorder_16x4: RTL

//  Records a player-entered button sequence into a 16-entry synchronous RAM.
//  It is the writer counterpart of the game's pre-programmed sequence ROM.
//  Its read port matches the ROM's: 4-bit address in, 7-bit data out, registered, 1-cycle latency.
//  The game datapath can therefore replay a recorded sequence in place of the fixed one.
//  It sits between the debounced button inputs and the sequence-memory mux in the datapath.

---
 rtl/sequence_recorder_16x4_pkg.sv | 21 ++
 rtl/sequence_recorder_16x4_sync_ram.sv | 34 +++
 rtl/sequence_recorder_16x4.sv | 95 +++++++++
 3 files changed

// File: rtl/sequence_recorder_16x4_pkg.sv
// rtl/sequence_recorder_16x4_pkg.sv - shared constants, state encoding and helpers for the sequence recorder
package sequence_recorder_16x4_pkg;

  localparam int SEQ_DEPTH  = 16;
  localparam int SEQ_ADDR_W = 4;
  localparam int SEQ_DATA_W = 7;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    ARMED   = 3'd1,
    ESPERA  = 3'd2,
    GRAVA   = 3'd3,
    SOLTA   = 3'd4,
    FIM     = 3'd5
  } state_t;

  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sequence_recorder_16x4_sync_ram.sv
// rtl/sequence_recorder_16x4_sync_ram.sv - 16-word RAM, one write port, registered read port, sync clear
module sync_ram_16x7
  import sequence_recorder_16x4_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  we,
  input  logic [SEQ_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [SEQ_ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [SEQ_DEPTH];

  // Read samples the array before this edge's update, so same-address access returns the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SEQ_DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
      if (clear) begin
        for (int i = 0; i < SEQ_DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
        mem[waddr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/sequence_recorder_16x4.sv
// rtl/sequence_recorder_16x4.sv - records single-button presses into a ROM-compatible 16x7 sequence RAM
module sequence_recorder_16x4
  import sequence_recorder_16x4_pkg::*;
#(
  parameter int DEPTH  = SEQ_DEPTH,
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic [3:0]        botoes,
  input  logic [3:0]        endereco,
  output logic [DATA_W-1:0] dado,
  output logic              gravando,
  output logic              cheio,
  output logic              pronto,
  output logic              invalido,
  output logic [4:0]        contagem
);

  state_t     state, nxt;
  logic [3:0] b_q;
  logic [3:0] val_q;
  logic       press;
  logic       we;
  logic       clear;
  logic       inv_set;
  logic       last_slot;

  assign press     = (b_q == 4'd0) && (botoes != 4'd0);
  assign cheio     = (contagem == 5'(DEPTH));
  assign last_slot = (contagem == 5'(DEPTH - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= INICIAL;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (iniciar) begin
      nxt = ARMED;
    end else begin
      case (state)
        INICIAL: nxt = INICIAL;
        ARMED:   if (parar) nxt = FIM; else if (botoes == 4'd0) nxt = ESPERA;
        ESPERA: begin
          if (parar)      nxt = FIM;
          else if (press) nxt = one_hot4(botoes) ? GRAVA : SOLTA;
        end
        GRAVA:   nxt = (parar || last_slot) ? FIM : SOLTA;
        SOLTA:   if (parar) nxt = FIM; else if (botoes == 4'd0) nxt = ESPERA;
        FIM:     nxt = FIM;
        default: nxt = INICIAL;
      endcase
    end
  end

  always_comb begin
    gravando = (state == ARMED) || (state == ESPERA) || (state == SOLTA);
    pronto   = (state == FIM);
    we       = (state == GRAVA) && !cheio;
    clear    = iniciar;
    inv_set  = (state == ESPERA) && !iniciar && !parar && press && !one_hot4(botoes);
  end

  // The press value is latched in ESPERA and written one cycle later from GRAVA.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_q      <= '0;
      val_q    <= '0;
      contagem <= '0;
      invalido <= 1'b0;
    end else begin
      b_q      <= botoes;
      invalido <= inv_set;
      if (state == ESPERA && press) val_q <= botoes;
      if (iniciar)  contagem <= '0;
      else if (we)  contagem <= contagem + 5'd1;
    end
  end

  sync_ram_16x7 #(.DATA_W(DATA_W)) u_ram (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .we    (we),
    .waddr (contagem[3:0]),
    .wdata ({{(DATA_W-4){1'b0}}, val_q}),
    .raddr (endereco),
    .rdata (dado)
  );

endmodule
